// File: rtl/niosqsys_ocimem_ctrl.sv
// Debug-RAM controller shared by the JTAG monitor path (MonAReg/MonDReg) and a CPU slave port.
// Define NIOSQSYS_OCIMEM_AUTOINC_EN to post-increment MonAReg after each JTAG access.
module niosqsys_ocimem_ctrl #(
    parameter int DEPTH = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [37:0] jdo,
    input  logic        take_action_ocimem_a,
    input  logic        take_no_action_ocimem_a,
    input  logic        take_action_ocimem_b,
    output logic [31:0] MonDReg,
    output logic        monitor_ready,
    output logic        monitor_error,
    input  logic [7:0]  cpu_address,
    input  logic        cpu_read,
    input  logic        cpu_write,
    input  logic [31:0] cpu_writedata,
    output logic        cpu_waitrequest,
    output logic [31:0] cpu_readdata,
    output logic        cpu_readdatavalid
);
    localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, JRD, CRD} state_t;

    state_t      state_q, state_d;
    logic [7:0]  mon_a_reg_q, mon_a_reg_d;
    logic [31:0] mon_d_reg_q, mon_d_reg_d;
    logic        ready_q, ready_d;
    logic        error_q, error_d;
    logic        rd_oor_q, rd_oor_d;
    logic        inc_pend_q, inc_pend_d;

    logic [31:0] ram_q [DEPTH];
    logic [31:0] ram_rdata_q;

    logic        act_a, act_b, act_nta, jtag_pulse, jtag_rd;
    logic        cpu_wr_acc, cpu_rd_acc;
    logic        rd_en, wr_en;
    logic [7:0]  rd_addr, wr_addr;
    logic [31:0] wr_data;
    logic        unused_jdo_bits;

    function automatic logic in_range(input logic [7:0] a);
        return ({1'b0, a} < 9'(DEPTH));
    endfunction

    assign unused_jdo_bits = ^{jdo[37:36], jdo[2:0]};

    // Pulse priority: a beats b beats no_action; losers are dropped.
    assign act_a      = take_action_ocimem_a;
    assign act_b      = take_action_ocimem_b & ~take_action_ocimem_a;
    assign act_nta    = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign jtag_pulse = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign jtag_rd    = (act_a & jdo[35]) | act_nta;

    assign cpu_waitrequest = jtag_pulse | (state_q == JRD);
    assign cpu_wr_acc      = cpu_write & ~cpu_waitrequest;
    assign cpu_rd_acc      = cpu_read & ~cpu_write & ~cpu_waitrequest;

    always_comb begin
        rd_en   = jtag_rd | cpu_rd_acc;
        rd_addr = cpu_address;
        if (jtag_rd) rd_addr = act_a ? jdo[33:26] : mon_a_reg_q;
        wr_en   = 1'b0;
        wr_addr = cpu_address;
        wr_data = cpu_writedata;
        if (act_b) begin
            wr_en   = in_range(mon_a_reg_q);
            wr_addr = mon_a_reg_q;
            wr_data = jdo[34:3];
        end else if (cpu_wr_acc) begin
            wr_en = in_range(cpu_address);
        end
    end

    // Storage is never reset; reads see the old word on a same-address write.
    always_ff @(posedge clk) begin
        if (wr_en) ram_q[wr_addr[IW-1:0]] <= wr_data;
        if (rd_en) ram_rdata_q <= ram_q[rd_addr[IW-1:0]];
    end

    always_comb begin
        state_d     = IDLE;
        mon_a_reg_d = mon_a_reg_q;
        mon_d_reg_d = mon_d_reg_q;
        ready_d     = ready_q;
        error_d     = error_q;
        rd_oor_d    = rd_oor_q;
        inc_pend_d  = 1'b0;

        if (jtag_rd)         state_d = JRD;
        else if (cpu_rd_acc) state_d = CRD;

        if (rd_en) rd_oor_d = ~in_range(rd_addr);

        if (state_q == JRD) begin
            mon_d_reg_d = rd_oor_q ? 32'd0 : ram_rdata_q;
            ready_d     = 1'b1;
            if (rd_oor_q) error_d = 1'b1;
        end

`ifdef NIOSQSYS_OCIMEM_AUTOINC_EN
        inc_pend_d = act_b | act_nta | (act_a & jdo[35]);
        if (inc_pend_q) mon_a_reg_d = mon_a_reg_q + 8'd1;
`endif

        // A fresh address load overrides any pending increment and clears status.
        if (act_a) begin
            mon_a_reg_d = jdo[33:26];
            ready_d     = 1'b0;
            error_d     = 1'b0;
        end

        if (act_b) begin
            mon_d_reg_d = jdo[34:3];
            if (!in_range(mon_a_reg_q)) error_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            mon_a_reg_q <= 8'd0;
            mon_d_reg_q <= 32'd0;
            ready_q     <= 1'b0;
            error_q     <= 1'b0;
            rd_oor_q    <= 1'b0;
            inc_pend_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            mon_a_reg_q <= mon_a_reg_d;
            mon_d_reg_q <= mon_d_reg_d;
            ready_q     <= ready_d;
            error_q     <= error_d;
            rd_oor_q    <= rd_oor_d;
            inc_pend_q  <= inc_pend_d;
        end
    end

    assign MonDReg           = mon_d_reg_q;
    assign monitor_ready     = ready_q;
    assign monitor_error     = error_q;
    assign cpu_readdatavalid = (state_q == CRD);
    assign cpu_readdata      = ((state_q == CRD) && !rd_oor_q) ? ram_rdata_q : 32'd0;

endmodule

// File: tb/tb_niosqsys_ocimem_ctrl.sv
// Bench for niosqsys_ocimem_ctrl: directed table, corner sequences, then random ops vs. a memory model.
module tb_niosqsys_ocimem_ctrl;
    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [37:0] jdo;
    logic        take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [31:0] MonDReg;
    logic        monitor_ready, monitor_error;
    logic [7:0]  cpu_address;
    logic        cpu_read, cpu_write;
    logic [31:0] cpu_writedata;
    logic        cpu_waitrequest;
    logic [31:0] cpu_readdata;
    logic        cpu_readdatavalid;

    int n_cmp = 0;
    int n_bad = 0;

    niosqsys_ocimem_ctrl #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .cpu_address(cpu_address), .cpu_read(cpu_read), .cpu_write(cpu_write),
        .cpu_writedata(cpu_writedata), .cpu_waitrequest(cpu_waitrequest),
        .cpu_readdata(cpu_readdata), .cpu_readdatavalid(cpu_readdatavalid)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          kind;   // 0 JTAG write, 1 JTAG read, 2 CPU write, 3 CPU read
        logic [7:0]  addr;
        logic [31:0] data;
        logic [31:0] exp_d;  // MonDReg, or cpu_readdata for kind 3
        logic        exp_rdy;
        logic        exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic jtag_a(input logic [7:0] addr, input logic rd);
        @(negedge clk);
        jdo = {2'b00, rd, 1'b0, addr, 26'd0};
        take_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0;
    endtask

    task automatic jtag_b(input logic [31:0] data);
        @(negedge clk);
        jdo = {3'b000, data, 3'b000};
        take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_b = 1'b0;
    endtask

    task automatic jtag_nta();
        @(negedge clk);
        take_no_action_ocimem_a = 1'b1;
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        @(negedge clk);
    endtask

    task automatic jtag_wr(input logic [7:0] addr, input logic [31:0] data);
        jtag_a(addr, 1'b0);
        jtag_b(data);
    endtask

    task automatic jtag_rd(input logic [7:0] addr);
        jtag_a(addr, 1'b1);
        @(negedge clk);
    endtask

    task automatic wait_accept(input string name);
        int t = 0;
        #1;
        while (cpu_waitrequest && t < 20) begin
            @(negedge clk);
            #1;
            t++;
        end
        if (t >= 20) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: waitrequest never dropped, got 1, expected 0", name);
        end
    endtask

    task automatic cpu_wr(input logic [7:0] addr, input logic [31:0] data);
        @(negedge clk);
        cpu_address = addr; cpu_writedata = data; cpu_write = 1'b1;
        wait_accept("cpu_wr_accept");
        @(negedge clk);
        cpu_write = 1'b0;
    endtask

    task automatic cpu_rd(input logic [7:0] addr, output logic [31:0] data, output logic vld);
        @(negedge clk);
        cpu_address = addr; cpu_read = 1'b1;
        wait_accept("cpu_rd_accept");
        @(negedge clk);
        cpu_read = 1'b0;
        data = cpu_readdata;
        vld  = cpu_readdatavalid;
        @(negedge clk);
        chk("cpu_rdv_one_cycle", {31'd0, cpu_readdatavalid}, 32'd0);
    endtask

    vec_t        tbl[14];
    logic [31:0] mem_m [256];
    logic [7:0]  mona_m;
    logic [31:0] mond_m;
    logic        rdy_m, err_m;
    logic [31:0] rdata;
    logic        rvld;

    initial begin
        jdo = '0; take_action_ocimem_a = 0; take_no_action_ocimem_a = 0; take_action_ocimem_b = 0;
        cpu_address = '0; cpu_read = 0; cpu_write = 0; cpu_writedata = '0;
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_mondreg", MonDReg, 32'd0);
        chk("rst_ready", {31'd0, monitor_ready}, 32'd0);
        chk("rst_error", {31'd0, monitor_error}, 32'd0);
        chk("rst_rdv", {31'd0, cpu_readdatavalid}, 32'd0);
        chk("rst_rdata", cpu_readdata, 32'd0);
        chk("rst_waitreq", {31'd0, cpu_waitrequest}, 32'd0);
        reset_n = 1'b1;

        tbl[0]  = '{0, 8'h05, 32'hCAFEF00D, 32'hCAFEF00D, 1'b0, 1'b0};
        tbl[1]  = '{1, 8'h05, 32'h0,        32'hCAFEF00D, 1'b1, 1'b0};
        tbl[2]  = '{2, 8'h7F, 32'h12345678, 32'hCAFEF00D, 1'b1, 1'b0};
        tbl[3]  = '{1, 8'h7F, 32'h0,        32'h12345678, 1'b1, 1'b0};
        tbl[4]  = '{3, 8'h7F, 32'h0,        32'h12345678, 1'b1, 1'b0};
        tbl[5]  = '{1, 8'h90, 32'h0,        32'h00000000, 1'b1, 1'b1};
        tbl[6]  = '{0, 8'h90, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[7]  = '{2, 8'h90, 32'h11111111, 32'hDEADBEEF, 1'b0, 1'b1};
        tbl[8]  = '{3, 8'h90, 32'h0,        32'h00000000, 1'b0, 1'b1};
        tbl[9]  = '{1, 8'h7F, 32'h0,        32'h12345678, 1'b1, 1'b0};
        tbl[10] = '{2, 8'h00, 32'hA5A5A5A5, 32'h12345678, 1'b1, 1'b0};
        tbl[11] = '{3, 8'h00, 32'h0,        32'hA5A5A5A5, 1'b1, 1'b0};
        tbl[12] = '{0, 8'h7F, 32'h0BADCAFE, 32'h0BADCAFE, 1'b0, 1'b0};
        tbl[13] = '{3, 8'h7F, 32'h0,        32'h0BADCAFE, 1'b0, 1'b0};

        for (int i = 0; i < 14; i++) begin
            case (tbl[i].kind)
                0: jtag_wr(tbl[i].addr, tbl[i].data);
                1: jtag_rd(tbl[i].addr);
                2: cpu_wr(tbl[i].addr, tbl[i].data);
                default: begin
                    cpu_rd(tbl[i].addr, rdata, rvld);
                    chk($sformatf("tbl%0d_rdv", i), {31'd0, rvld}, 32'd1);
                    chk($sformatf("tbl%0d_rdata", i), rdata, tbl[i].exp_d);
                end
            endcase
            if (tbl[i].kind != 3) chk($sformatf("tbl%0d_mondreg", i), MonDReg, tbl[i].exp_d);
            chk($sformatf("tbl%0d_ready", i), {31'd0, monitor_ready}, {31'd0, tbl[i].exp_rdy});
            chk($sformatf("tbl%0d_error", i), {31'd0, monitor_error}, {31'd0, tbl[i].exp_err});
        end

        // Simultaneous a+b: address loads, write dropped.
        cpu_wr(8'h20, 32'h00000055);
        cpu_wr(8'h21, 32'h00000066);
        cpu_wr(8'h10, 32'h1010BEEF);
        cpu_wr(8'h00, 32'h0A0A0A0A);
        jtag_wr(8'h22, 32'h00000077);
        @(negedge clk);
        jdo = {2'b00, 1'b0, 1'b0, 8'h21, 26'h3ABCDEF};
        take_action_ocimem_a = 1'b1; take_action_ocimem_b = 1'b1;
        @(negedge clk);
        take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        chk("simul_mondreg", MonDReg, 32'h00000077);
        chk("simul_ready", {31'd0, monitor_ready}, 32'd0);
        jtag_nta();
        chk("simul_addr_loaded", MonDReg, 32'h00000066);
        jtag_rd(8'h22);
        chk("simul_ram_unchanged", MonDReg, 32'h00000077);

        // Streaming read after a JTAG read.
        jtag_rd(8'h20);
        chk("stream_first", MonDReg, 32'h00000055);
        jtag_nta();
`ifdef NIOSQSYS_OCIMEM_AUTOINC_EN
        chk("stream_next", MonDReg, 32'h00000066);
`else
        chk("stream_next", MonDReg, 32'h00000055);
`endif

        // Address 8'hFF: out of range read, then streaming from there.
        jtag_rd(8'hFF);
        chk("ff_mondreg", MonDReg, 32'd0);
        chk("ff_ready", {31'd0, monitor_ready}, 32'd1);
        chk("ff_error", {31'd0, monitor_error}, 32'd1);
        jtag_nta();
`ifdef NIOSQSYS_OCIMEM_AUTOINC_EN
        chk("ff_wrap_mondreg", MonDReg, 32'h0A0A0A0A);
`else
        chk("ff_wrap_mondreg", MonDReg, 32'd0);
`endif
        chk("ff_wrap_error", {31'd0, monitor_error}, 32'd1);

        // Collision: CPU read alongside a streaming read.
        @(negedge clk);
        cpu_address = 8'h10; cpu_read = 1'b1; take_no_action_ocimem_a = 1'b1;
        #1;
        chk("coll_wait_c1", {31'd0, cpu_waitrequest}, 32'd1);
        @(negedge clk);
        take_no_action_ocimem_a = 1'b0;
        #1;
        chk("coll_wait_c2", {31'd0, cpu_waitrequest}, 32'd1);
        @(negedge clk);
        #1;
        chk("coll_wait_c3", {31'd0, cpu_waitrequest}, 32'd0);
        chk("coll_rdv_c3", {31'd0, cpu_readdatavalid}, 32'd0);
        @(negedge clk);
        cpu_read = 1'b0;
        chk("coll_rdv_c4", {31'd0, cpu_readdatavalid}, 32'd1);
        chk("coll_rdata_c4", cpu_readdata, 32'h1010BEEF);
        @(negedge clk);
        chk("coll_rdv_c5", {31'd0, cpu_readdatavalid}, 32'd0);

        // Reset asserted while a JTAG read is in flight.
        jtag_a(8'h20, 1'b1);
        reset_n = 1'b0;
        #1;
        chk("rstmid_mondreg", MonDReg, 32'd0);
        chk("rstmid_ready", {31'd0, monitor_ready}, 32'd0);
        chk("rstmid_error", {31'd0, monitor_error}, 32'd0);
        chk("rstmid_rdv", {31'd0, cpu_readdatavalid}, 32'd0);
        chk("rstmid_waitreq", {31'd0, cpu_waitrequest}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("rstmid_ready_after", {31'd0, monitor_ready}, 32'd0);
        chk("rstmid_mondreg_after", MonDReg, 32'd0);

        // Random phase: fill RAM, then random operations against the model.
        for (int a = 0; a < 256; a++) mem_m[a] = 32'd0;
        for (int a = 0; a < DEPTH; a++) begin
            mem_m[a] = $urandom;
            cpu_wr(8'(a), mem_m[a]);
        end
        jtag_rd(8'h00);
        mona_m = 8'h00; mond_m = mem_m[0]; rdy_m = 1'b1; err_m = 1'b0;
`ifdef NIOSQSYS_OCIMEM_AUTOINC_EN
        mona_m = mona_m + 8'd1;
`endif
        for (int i = 0; i < 300; i++) begin
            int          kind;
            logic [7:0]  addr;
            logic [31:0] data;
            kind = int'($urandom_range(0, 4));
            addr = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : 8'($urandom_range(0, DEPTH - 1));
            data = $urandom;
            case (kind)
                0: begin
                    jtag_wr(addr, data);
                    mona_m = addr; rdy_m = 1'b0; err_m = 1'b0;
                    if (int'(addr) < DEPTH) mem_m[addr] = data; else err_m = 1'b1;
                    mond_m = data;
`ifdef NIOSQSYS_OCIMEM_AUTOINC_EN
                    mona_m = mona_m + 8'd1;
`endif
                end
                1, 2: begin
                    if (kind == 1) begin
                        jtag_rd(addr);
                        mona_m = addr; err_m = 1'b0;
                    end else begin
                        jtag_nta();
                    end
                    mond_m = (int'(mona_m) < DEPTH) ? mem_m[mona_m] : 32'd0;
                    if (int'(mona_m) >= DEPTH) err_m = 1'b1;
                    rdy_m = 1'b1;
`ifdef NIOSQSYS_OCIMEM_AUTOINC_EN
                    mona_m = mona_m + 8'd1;
`endif
                end
                3: begin
                    cpu_wr(addr, data);
                    if (int'(addr) < DEPTH) mem_m[addr] = data;
                end
                default: begin
                    cpu_rd(addr, rdata, rvld);
                    chk($sformatf("rnd%0d_rdv", i), {31'd0, rvld}, 32'd1);
                    chk($sformatf("rnd%0d_rdata@%h", i, addr), rdata,
                        (int'(addr) < DEPTH) ? mem_m[addr] : 32'd0);
                end
            endcase
            chk($sformatf("rnd%0d_mondreg", i), MonDReg, mond_m);
            chk($sformatf("rnd%0d_ready", i), {31'd0, monitor_ready}, {31'd0, rdy_m});
            chk($sformatf("rnd%0d_error", i), {31'd0, monitor_error}, {31'd0, err_m});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/niosqsys_ocimem_ctrl.md
NIOSQSYS_OCIMEM_CTRL -- requirements
Module: niosqsys_ocimem_ctrl

Interface
REQ-001 Parameter DEPTH, default 128, the number of 32-bit words in the debug RAM; legal range 2..256.
REQ-002 clk  in  1  sole clock; every flop is rising-edge.
REQ-003 reset_n  in  1  asynchronous reset, active-low.
REQ-004 jdo  in  38  JTAG data word from the debug-module sysclk stage.
REQ-005 take_action_ocimem_a  in  1  one-cycle pulse: load address, optionally read.
REQ-006 take_no_action_ocimem_a  in  1  one-cycle pulse: streaming read.
REQ-007 take_action_ocimem_b  in  1  one-cycle pulse: write.
REQ-008 MonDReg  out  32  monitor data register, returned to the debug module.
REQ-009 monitor_ready  out  1  MonDReg holds valid JTAG read data.
REQ-010 monitor_error  out  1  sticky flag for an out-of-range access.
REQ-011 cpu_address  in  8  CPU word address.
REQ-012 cpu_read  in  1  CPU read request.
REQ-013 cpu_write  in  1  CPU write request.
REQ-014 cpu_writedata  in  32  CPU write data.
REQ-015 cpu_waitrequest  out  1  CPU request not accepted this cycle.
REQ-016 cpu_readdata  out  32  CPU read data.
REQ-017 cpu_readdatavalid  out  1  cpu_readdata valid this cycle.

Function
REQ-018 Storage SHALL be a DEPTH x 32 synchronous RAM with 1-cycle read latency; addresses >= DEPTH SHALL be out of range.
REQ-019 On take_action_ocimem_a the block SHALL do all of the following:
- load MonAReg <= jdo[33:26];
- clear monitor_ready and monitor_error;
- if jdo[35]=1, issue a read at the new address.
REQ-020 On take_no_action_ocimem_a the block SHALL issue a read at MonAReg.
REQ-021 On take_action_ocimem_b the block SHALL write jdo[34:3] to RAM[MonAReg] and to MonDReg.
REQ-022 JTAG read timing: issued in cycle N, then MonDReg loaded at the end of N+1 and monitor_ready=1 from cycle N+2.
REQ-023 FSM states SHALL be IDLE, JRD and CRD:
- IDLE->JRD on a JTAG read; JRD->IDLE after one cycle;
- IDLE->CRD on an accepted CPU read; CRD->IDLE after one cycle;
- a JTAG read in CRD SHALL go to JRD.
REQ-024 Priority: take_action_ocimem_a over take_action_ocimem_b over take_no_action_ocimem_a; lower-priority pulses in the same cycle SHALL be dropped.
REQ-025 JTAG SHALL have priority over CPU: cpu_waitrequest=1 in any cycle with a JTAG pulse or state JRD, otherwise 0.
REQ-026 An accepted CPU read SHALL assert cpu_readdatavalid for exactly one cycle, the next cycle, with cpu_readdata=RAM[cpu_address].
REQ-027 An accepted CPU write SHALL update RAM at the clock edge and SHALL leave MonDReg and monitor_ready unchanged.
REQ-028 cpu_read and cpu_write asserted together SHALL perform the write only.
REQ-029 Out-of-range JTAG access SHALL set monitor_error:
- read: load MonDReg=0 and still set monitor_ready;
- write: RAM unchanged, MonDReg still loaded.
REQ-030 Out-of-range CPU access SHALL return 0 on reads, ignore writes, and SHALL NOT set monitor_error.
REQ-031 A CPU write and a JTAG read of the same address in one cycle cannot occur, because REQ-025 stalls the CPU.

Reset
REQ-032 While reset_n=0 the block SHALL hold MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, cpu_readdatavalid=0, cpu_readdata=0, cpu_waitrequest=0, FSM=IDLE.
REQ-033 RAM contents SHALL NOT be reset.
REQ-034 A read in flight at reset assertion SHALL be discarded, with no readdatavalid or monitor_ready after release.

Configuration
REQ-035 Macro NIOSQSYS_OCIMEM_AUTOINC_EN, when defined, SHALL make the following increment MonAReg by 1 modulo 256 (8'hFF->8'h00) one cycle after the access:
- take_no_action_ocimem_a;
- take_action_ocimem_b;
- take_action_ocimem_a with jdo[35]=1.
REQ-036 When NIOSQSYS_OCIMEM_AUTOINC_EN is undefined, MonAReg SHALL change only on take_action_ocimem_a.

Verification
REQ-037 Write then read back:
- stimulus: ocimem_a with jdo[33:26]=8'h05, jdo[35]=0; then ocimem_b with jdo[34:3]=32'hCAFEF00D; then ocimem_a with address 8'h05, jdo[35]=1;
- response: MonDReg=32'hCAFEF00D and monitor_ready=1 two cycles after the last pulse.
REQ-038 AUTOINC_EN defined, address wrap:
- stimulus: ocimem_a with address 8'hFF, jdo[35]=1;
- response: MonAReg=8'h00 afterwards, monitor_error=1, MonDReg=0.
REQ-039 Collision:
- stimulus: cpu_read at 8'h10 in the same cycle as take_no_action_ocimem_a;
- response: cpu_waitrequest=1 that cycle and the next; CPU accepted in the third cycle; cpu_readdatavalid in the fourth.
REQ-040 Simultaneous pulses:
- stimulus: ocimem_a and ocimem_b in the same cycle;
- response: address loaded, RAM unchanged, MonDReg unchanged.
REQ-041 Reset mid-read:
- stimulus: reset_n=0 one cycle after a JTAG read is issued;
- response: all outputs 0; monitor_ready stays 0 after release.
REQ-042 CPU write isolation:
- stimulus: cpu_write 32'h12345678 to 8'h7F;
- response: JTAG read of 8'h7F returns 32'h12345678; MonDReg unchanged before that read.
